// File: rtl/status_value_vector.sv
// ---------------------------------------------------------------------------
// status_value_vector
//   A small FIFO ("status vector") with one extra operation: set, which
//   overwrites the newest stored entry in place. Storage is a circular buffer
//   of DEPTH x WIDTH register entries. The entries use a read pointer, a write
//   pointer and an occupancy count.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 2)
//   WIDTH        bits per entry
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rsn_i        synchronous active-low reset
//   push_i       append value_i as the newest entry
//   pull_i       remove the oldest entry
//   value_i      value appended on push
//   set_i        overwrite the newest stored entry with set_value_i
//   set_value_i  value written on set
//   value_o      oldest entry (0 when empty)
//   valid_o      at least one entry stored
//   full_o       DEPTH entries stored
//
// All outputs are decoded from registered state only. There is no path from
// any input to any output.
// ---------------------------------------------------------------------------
module status_value_vector #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             push_i,
    input  logic             pull_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             set_i,
    input  logic [WIDTH-1:0] set_value_i,
    output logic [WIDTH-1:0] value_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             pull_ok;
    logic             push_ok;
    logic             set_ok;
    logic [AW-1:0]    set_addr;

    // Acceptance rules. A push into a full vector is only possible when a pull
    // frees a slot on the same edge. A pull from an empty vector is ignored,
    // even when a push arrives together with it, so the empty vector is never
    // bypassed. A set needs a stored target. The set is dropped when the
    // target (the only entry) leaves through a simultaneous pull.
    always_comb begin
        pull_ok  = pull_i && (count_q != '0);
        push_ok  = push_i && ((count_q != FULL_C) || pull_ok);
        set_ok   = set_i && (count_q != '0) &&
                   !((count_q == (AW+1)'(1)) && pull_ok);
        // The newest entry present before this edge sits just behind wr_ptr.
        set_addr = wr_ptr_q - AW'(1);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pull_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push_ok && !pull_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pull_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared by reset. The pointers and the count alone decide
    // what is visible. The push slot (wr_ptr) and the set slot (wr_ptr-1)
    // never coincide because DEPTH >= 2.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk_i) begin
            if (rsn_i) begin
                if (push_ok && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= value_i;
                end else if (set_ok && (set_addr == AW'(gi))) begin
                    mem_q[gi] <= set_value_i;
                end
            end
        end
    end

    always_comb begin
        valid_o = (count_q != '0);
        full_o  = (count_q == FULL_C);
        value_o = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_status_value_vector.sv
module tb_status_value_vector;

    logic       clk_i = 1'b0;
    logic       rsn_i = 1'b0;
    logic       push_i = 1'b0;
    logic       pull_i = 1'b0;
    logic [3:0] value_i = '0;
    logic       set_i = 1'b0;
    logic [3:0] set_value_i = '0;
    logic [3:0] value_o;
    logic       valid_o;
    logic       full_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stored entries, oldest at index 0.
    logic [3:0] mq[$];

    status_value_vector #(.DEPTH(32), .WIDTH(4)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .push_i(push_i), .pull_i(pull_i),
        .value_i(value_i), .set_i(set_i), .set_value_i(set_value_i),
        .value_o(value_o), .valid_o(valid_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] exp_out();
        logic [3:0] v;
        v = (mq.size() != 0) ? mq[0] : 4'h0;
        return {mq.size() != 0, mq.size() == 32, v};
    endfunction

    function automatic logic [5:0] got_out();
        return {valid_o, full_o, value_o};
    endfunction

    // Drive one clock cycle and advance the model by the same rules. The
    // outputs are then sampled 1 time unit after the edge.
    task automatic do_cycle(input bit rst_n, input bit push, input bit pull,
                            input bit set, input logic [3:0] v,
                            input logic [3:0] sv);
        bit pull_ok, push_ok, set_ok;
        @(negedge clk_i);
        rsn_i = rst_n; push_i = push; pull_i = pull; set_i = set;
        value_i = v; set_value_i = sv;
        @(posedge clk_i);
        if (!rst_n) begin
            mq.delete();
        end else begin
            pull_ok = pull && (mq.size() > 0);
            push_ok = push && ((mq.size() < 32) || pull_ok);
            set_ok  = set && (mq.size() > 0) && !((mq.size() == 1) && pull_ok);
            if (set_ok)  mq[mq.size()-1] = sv;
            if (pull_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(v);
        end
        #1;
    endtask

    task automatic test_reset();
        do_cycle(0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL reset_state got=%h exp=%h", got_out(), 6'h00);
        end
        // Reset overrides a simultaneous push, pull and set.
        do_cycle(0, 1, 1, 1, 4'h9, 4'h3);
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL reset_override got=%h exp=%h", got_out(), 6'h00);
        end
    endtask

    task automatic test_push_pull();
        for (int i = 1; i <= 10; i++) do_cycle(1, 1, 0, 0, 4'(i), 0);
        n_cmp++;
        if (got_out() !== 6'h21 || got_out() !== exp_out()) begin
            n_bad++; $display("FAIL push10 got=%h exp=%h", got_out(), 6'h21);
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1, 0, 1, 0, 0, 0);
            n_cmp++;
            if (got_out() !== {2'b10, 4'(i + 2)}) begin
                n_bad++; $display("FAIL pull5_%0d got=%h exp=%h", i, got_out(), {2'b10, 4'(i + 2)});
            end
        end
        n_cmp++;
        if (mq.size() != 5 || got_out() !== exp_out()) begin
            n_bad++; $display("FAIL remain5 got=%h exp=%h", got_out(), exp_out());
        end
    endtask

    task automatic test_full();
        logic [3:0] exp_vals[$];
        do_cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            exp_vals.push_back(4'($urandom_range(0, 14)));
            do_cycle(1, 1, 0, 0, exp_vals[i], 0);
        end
        n_cmp++;
        if (got_out() !== {2'b11, exp_vals[0]}) begin
            n_bad++; $display("FAIL full32 got=%h exp=%h", got_out(), {2'b11, exp_vals[0]});
        end
        do_cycle(1, 1, 0, 0, 4'hF, 0);
        n_cmp++;
        if (got_out() !== {2'b11, exp_vals[0]}) begin
            n_bad++; $display("FAIL full_drop got=%h exp=%h", got_out(), {2'b11, exp_vals[0]});
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (value_o !== exp_vals[i]) begin
                n_bad++; $display("FAIL drain_%0d got=%h exp=%h", i, value_o, exp_vals[i]);
            end
            do_cycle(1, 0, 1, 0, 0, 0);
        end
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL drained_empty got=%h exp=%h", got_out(), 6'h00);
        end
    endtask

    task automatic test_set();
        do_cycle(1, 1, 0, 0, 4'h3, 0);
        do_cycle(1, 1, 0, 0, 4'h7, 0);
        do_cycle(1, 0, 0, 1, 0, 4'hA);
        n_cmp++;
        if (got_out() !== 6'h23) begin
            n_bad++; $display("FAIL set_head got=%h exp=%h", got_out(), 6'h23);
        end
        do_cycle(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got_out() !== 6'h2A) begin
            n_bad++; $display("FAIL set_newest got=%h exp=%h", got_out(), 6'h2A);
        end
        do_cycle(1, 0, 1, 0, 0, 0);
        do_cycle(1, 0, 0, 1, 0, 4'h5);
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL set_empty got=%h exp=%h", got_out(), 6'h00);
        end
        // Set with a push: set hits the old newest entry, push keeps value_i.
        do_cycle(1, 1, 0, 0, 4'h1, 0);
        do_cycle(1, 1, 0, 1, 4'h2, 4'hC);
        n_cmp++;
        if (got_out() !== 6'h2C) begin
            n_bad++; $display("FAIL set_push got=%h exp=%h", got_out(), 6'h2C);
        end
        do_cycle(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got_out() !== 6'h22) begin
            n_bad++; $display("FAIL set_push2 got=%h exp=%h", got_out(), 6'h22);
        end
        // Count=1, set and pull together: the set is dropped.
        do_cycle(1, 0, 1, 1, 0, 4'h8);
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL set_pull_one got=%h exp=%h", got_out(), 6'h00);
        end
    endtask

    task automatic test_simul();
        logic [3:0] last;
        for (int i = 0; i < 32; i++) do_cycle(1, 1, 0, 0, 4'(i), 0);
        last = 4'($urandom_range(0, 15));
        do_cycle(1, 1, 1, 0, last, 0);
        n_cmp++;
        if (got_out() !== {2'b11, 4'h1}) begin
            n_bad++; $display("FAIL full_pushpull got=%h exp=%h", got_out(), {2'b11, 4'h1});
        end
        for (int i = 0; i < 31; i++) do_cycle(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got_out() !== {2'b10, last}) begin
            n_bad++; $display("FAIL full_pushpull_last got=%h exp=%h", got_out(), {2'b10, last});
        end
        do_cycle(1, 0, 1, 0, 0, 0);
        do_cycle(1, 1, 1, 0, 4'h6, 0);
        n_cmp++;
        if (got_out() !== 6'h26 || mq.size() != 1) begin
            n_bad++; $display("FAIL empty_pushpull got=%h exp=%h", got_out(), 6'h26);
        end
        do_cycle(1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_wrap();
        int pushes = 0, pulls = 0;
        bit p, q;
        while (pushes < 40 || pulls < 40) begin
            p = (pushes < 40) && ($urandom_range(0, 3) != 0);
            q = (pulls < pushes) && ($urandom_range(0, 2) != 0);
            if (pushes >= 40) q = 1;
            do_cycle(1, p, q, 0, 4'($urandom), 0);
            if (p) pushes++;
            if (q) pulls++;
            n_cmp++;
            if (got_out() !== exp_out()) begin
                n_bad++; $display("FAIL wrap got=%h exp=%h", got_out(), exp_out());
            end
        end
        for (int i = 0; i < 5; i++) do_cycle(1, 1, 0, 0, 4'(i + 9), 0);
        do_cycle(0, 1, 0, 0, 4'h4, 0);
        n_cmp++;
        if (got_out() !== 6'h00) begin
            n_bad++; $display("FAIL midreset got=%h exp=%h", got_out(), 6'h00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                     4'($urandom), 4'($urandom));
            n_cmp++;
            if (got_out() !== exp_out()) begin
                n_bad++; $display("FAIL random_%0d got=%h exp=%h", i, got_out(), exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pull();
        test_full();
        test_set();
        test_simul();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
